arch_map_table_gen2: RTL and testbench
======================================

# arch_map_table_gen2

Parametrised architectural map table (AMT) for the retire stage. It sits between the Active List and the rename map table (RMT)/free list. On each commit it records the youngest logical→physical mapping per logical register and releases superseded physical registers to the free list. On exception or mispredict recovery it streams the full architectural map to the RMT in groups, under a ready/valid handshake and a small state machine, so the RMT can accept fewer entries per cycle without losing data.

## Interface
- COMMIT_WIDTH, 4: retire slots per cycle; slot 0 is oldest.
- NUM_LOG, 32: logical registers; must be a power of 2.
- LOG_W, 5: log2(NUM_LOG).
- PHYS_W, 7: physical register tag width; 2^PHYS_W ≥ NUM_LOG.
- RECOVER_WIDTH, 4: entries sent per recovery beat; power of 2 and ≤ NUM_LOG.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- commitValid_i  in  COMMIT_WIDTH  slot k retires an instruction with a destination.
- commitLogDest_i  in  COMMIT_WIDTH*LOG_W  logical dest per slot; slot k is bits [k*LOG_W +: LOG_W].
- commitPhyDest_i  in  COMMIT_WIDTH*PHYS_W  new physical tag per slot.
- releasedValid_o  out  COMMIT_WIDTH  slot k releases a tag this cycle.
- releasedPhyMap_o  out  COMMIT_WIDTH*PHYS_W  released tag per slot.
- recoverFlag_i  in  1  start recovery; single-cycle pulse from the Active List.
- recoverReady_i  in  1  RMT accepts the current recovery beat.
- recoverValid_o  out  1  recovery beat present.
- recoverLogReg_o  out  RECOVER_WIDTH*LOG_W  logical index per lane; lane i = base+i.
- recoverPhyMap_o  out  RECOVER_WIDTH*PHYS_W  AMT contents per lane.
- recoverBusy_o  out  1  state ≠ IDLE.
- recoverDone_o  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Storage: NUM_LOG×PHYS_W flop array. On reset, entry i = i (identity map). The recovery counter is 0, the state is IDLE, and all outputs are 0. recoverLogReg_o has no reset requirement.
- Commit, in IDLE or in the cycle recoverFlag_i is sampled:
  - Slot k is *superseded* if some j>k has commitValid_i[j]=1 and the same logical dest.
  - Only non-superseded valid slots write AMT[dest_k]=phy_k. At most one write per address per cycle.
  - releasedValid_o[k] = commitValid_i[k].
  - releasedPhyMap_o[k] = phy_k if slot k is superseded; otherwise AMT[dest_k] as held before this edge. The release is combinational and does not bypass same-cycle writes.
  - Invalid slots are ignored entirely, including in the superseded test.
- FSM states: IDLE, STREAM, DONE.
  - IDLE→STREAM when recoverFlag_i=1. The base counter is set to 0. Commits in that cycle are applied first, so the stream reflects them.
  - STREAM: recoverValid_o=1. Lane i carries logical reg base+i and AMT[base+i]. A beat transfers when recoverValid_o && recoverReady_i. On transfer, base += RECOVER_WIDTH, as LOG_W-bit arithmetic that wraps to 0. The transfer of base = NUM_LOG−RECOVER_WIDTH moves the FSM to DONE.
  - DONE: recoverDone_o=1 for one cycle, then IDLE.
  - While not IDLE, commitValid_i is ignored: no AMT write, releasedValid_o=0, and the table is frozen. recoverFlag_i is ignored.
  - recoverValid_o, once high, stays high with stable data until accepted.
- Asynchronous reset asserted at any time, including mid-stream, forces the identity map, IDLE, and zero outputs immediately. No partial stream resumes after reset.

## Timing
- Commit path: zero latency to releasedPhyMap_o. The AMT update is visible to reads the next cycle.
- Recovery: recoverFlag_i at edge T. recoverValid_o is high from T+1.
- With recoverReady_i held at 1, beats occupy T+1 … T+NUM_LOG/RECOVER_WIDTH. recoverDone_o is high in the following cycle. recoverBusy_o drops the cycle after that.
- Defaults: 8 beats, done at T+9, IDLE at T+10.
- Each cycle recoverReady_i is low adds one cycle.
- recoverBusy_o, recoverValid_o and recoverDone_o are decoded from registered state only, with no combinational path from inputs.

## Test plan
- Reset, then pulse recoverFlag_i with ready=1: 8 beats, and beat n shows logical 4n..4n+3 mapped to phys 4n..4n+3. recoverDone_o pulses one cycle after beat 7.
- Commit slot0 r5→p40: released tag p5. The next recovery beat 1, lane 1, shows r5→p40.
- WAW within a group: slots 0, 2 and 3 valid, all targeting r7 with p33, p34 and p35. Released tags are p33, p34 and p7. AMT[r7]=p35. Slot 1 is invalid with r7 and p99, and is ignored.
- Backpressure: during recovery, toggle recoverReady_i 1,0,0,1,…. Data and valid hold while stalled, no beat is skipped or repeated, and done arrives 2 cycles late per stall.
- Commit during STREAM: commitValid_i=4'b1111 gives releasedValid_o=0 and no AMT change, checked by a second recovery. A recoverFlag_i pulse mid-stream does not restart the counter.
- Assert reset mid-recovery at beat 3: outputs go to 0 asynchronously. After release, a fresh recovery shows the identity map.

Source files
------------

// File: rtl/arch_map_table_gen2.sv
// Architectural map table: commit-time mapping update with superseded-tag
// release, and a grouped ready/valid stream of the full map for recovery.

// Per commit slot: decide whether a younger slot overwrites this one and
// pick the tag handed back to the free list.
module arch_map_table_gen2_slot #(
  parameter int COMMIT_WIDTH = 4,
  parameter int LOG_W        = 5,
  parameter int PHYS_W       = 7,
  parameter int SLOT         = 0
) (
  input  logic                          en,
  input  logic [COMMIT_WIDTH-1:0]       valid,
  input  logic [COMMIT_WIDTH*LOG_W-1:0] dest,
  input  logic [PHYS_W-1:0]             phy,
  input  logic [PHYS_W-1:0]             amt_rd,
  output logic                          rel_vld,
  output logic [PHYS_W-1:0]             rel_tag
);
  logic sup;

  // superseded when any younger valid slot targets the same logical reg
  always_comb begin
    sup = 1'b0;
    for (int j = 0; j < COMMIT_WIDTH; j++)
      if (j > SLOT && valid[j] && dest[j*LOG_W +: LOG_W] == dest[SLOT*LOG_W +: LOG_W])
        sup = 1'b1;
  end

  assign rel_vld = en && valid[SLOT];
  assign rel_tag = !rel_vld ? '0 : (sup ? phy : amt_rd);
endmodule

module arch_map_table_gen2 #(
  parameter int COMMIT_WIDTH  = 4,
  parameter int NUM_LOG       = 32,
  parameter int LOG_W         = 5,
  parameter int PHYS_W        = 7,
  parameter int RECOVER_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [COMMIT_WIDTH-1:0]         commitValid_i,
  input  logic [COMMIT_WIDTH*LOG_W-1:0]   commitLogDest_i,
  input  logic [COMMIT_WIDTH*PHYS_W-1:0]  commitPhyDest_i,
  output logic [COMMIT_WIDTH-1:0]         releasedValid_o,
  output logic [COMMIT_WIDTH*PHYS_W-1:0]  releasedPhyMap_o,
  input  logic                            recoverFlag_i,
  input  logic                            recoverReady_i,
  output logic                            recoverValid_o,
  output logic [RECOVER_WIDTH*LOG_W-1:0]  recoverLogReg_o,
  output logic [RECOVER_WIDTH*PHYS_W-1:0] recoverPhyMap_o,
  output logic                            recoverBusy_o,
  output logic                            recoverDone_o
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [LOG_W-1:0] LAST_BASE = LOG_W'(NUM_LOG - RECOVER_WIDTH);
  localparam logic [LOG_W-1:0] STEP      = LOG_W'(RECOVER_WIDTH);

  state_t                         state;
  logic [LOG_W-1:0]               base;
  logic                           valid_q, busy_q, done_q;
  logic [NUM_LOG-1:0][PHYS_W-1:0] amt;
  logic                           commit_en;

  // commits only land while idle (which includes the recovery-start cycle);
  // reset also silences the release path
  assign commit_en = (state == IDLE) && reset;

  // map table: identity on reset; younger slots are written last so they win
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LOG; i++) amt[i] <= PHYS_W'(i);
    end else if (state == IDLE) begin
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (commitValid_i[k])
          amt[commitLogDest_i[k*LOG_W +: LOG_W]] <= commitPhyDest_i[k*PHYS_W +: PHYS_W];
    end
  end

  genvar g;
  generate
    for (g = 0; g < COMMIT_WIDTH; g++) begin : g_slot
      arch_map_table_gen2_slot #(
        .COMMIT_WIDTH(COMMIT_WIDTH), .LOG_W(LOG_W), .PHYS_W(PHYS_W), .SLOT(g)
      ) u_slot (
        .en      (commit_en),
        .valid   (commitValid_i),
        .dest    (commitLogDest_i),
        .phy     (commitPhyDest_i[g*PHYS_W +: PHYS_W]),
        .amt_rd  (amt[commitLogDest_i[g*LOG_W +: LOG_W]]),
        .rel_vld (releasedValid_o[g]),
        .rel_tag (releasedPhyMap_o[g*PHYS_W +: PHYS_W])
      );
    end
    for (g = 0; g < RECOVER_WIDTH; g++) begin : g_lane
      logic [LOG_W-1:0] idx;
      assign idx = base + LOG_W'(g);
      assign recoverLogReg_o[g*LOG_W +: LOG_W]   = idx;
      assign recoverPhyMap_o[g*PHYS_W +: PHYS_W] = valid_q ? amt[idx] : '0;
    end
  endgenerate

  // recovery sequencer with registered valid/busy/done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      base    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (recoverFlag_i) begin
          state   <= STREAM;
          base    <= '0;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        STREAM: if (recoverReady_i) begin
          base <= base + STEP;
          if (base == LAST_BASE) begin
            state   <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign recoverValid_o = valid_q;
  assign recoverBusy_o  = busy_q;
  assign recoverDone_o  = done_q;
endmodule

// File: tb/tb_arch_map_table_gen2.sv
// Directed bench for arch_map_table_gen2: commit/release vectors from a
// table, plus hand sequences for recovery, backpressure and mid-stream reset.
module tb_arch_map_table_gen2;
  logic        clk = 0, reset = 0;
  logic [3:0]  cv = 0;
  logic [19:0] cd = 0;
  logic [27:0] cp = 0;
  logic [3:0]  rel_v;
  logic [27:0] rel_p;
  logic        flag = 0, rdy = 1;
  logic        rvalid, busy, done;
  logic [19:0] rlog;
  logic [27:0] rphy;

  int nvec = 0, nerr = 0;
  logic [6:0] exp_amt [32];

  arch_map_table_gen2 dut (
    .clk(clk), .reset(reset),
    .commitValid_i(cv), .commitLogDest_i(cd), .commitPhyDest_i(cp),
    .releasedValid_o(rel_v), .releasedPhyMap_o(rel_p),
    .recoverFlag_i(flag), .recoverReady_i(rdy),
    .recoverValid_o(rvalid), .recoverLogReg_o(rlog), .recoverPhyMap_o(rphy),
    .recoverBusy_o(busy), .recoverDone_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [19:0] dest;
    logic [27:0] phy;
    logic [3:0]  exp_rv;
    logic [27:0] exp_rel;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] pd(input int s3, input int s2, input int s1, input int s0);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction
  function automatic logic [27:0] pp(input int s3, input int s2, input int s1, input int s0);
    return {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
  endfunction

  task automatic set_identity();
    for (int i = 0; i < 32; i++) exp_amt[i] = 7'(i);
  endtask

  // stall: ready pattern 1,0,0,1 repeating; perturb: commit with the flag,
  // then commits plus a second flag while streaming
  task automatic do_recovery(input bit stall, input bit perturb, input int exp_cycles);
    int beat, cyc;
    logic [19:0] el;
    logic [27:0] ep;
    @(negedge clk);
    flag = 1;
    if (perturb) begin
      cv = 4'b0001; cd = pd(0, 0, 0, 10); cp = pp(0, 0, 0, 90);
      #1;
      check("flag_cycle_rel_valid", rel_v, 4'b0001);
      check("flag_cycle_rel_tag", rel_p[6:0], 7'd10);
    end
    @(negedge clk);
    flag = 0; cv = 0;
    beat = 0; cyc = 0;
    while (beat < 8 && cyc < 100) begin
      rdy = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (perturb && cyc == 2) begin
        cv = 4'b1111; cd = pd(4, 3, 2, 1); cp = pp(103, 102, 101, 100); flag = 1;
        #1;
        check("stream_commit_ignored", rel_v, 4'b0000);
      end else begin
        cv = 0; flag = 0;
      end
      for (int i = 0; i < 4; i++) begin
        el[i*5 +: 5] = 5'(4 * beat + i);
        ep[i*7 +: 7] = exp_amt[4 * beat + i];
      end
      check("stream_valid", rvalid, 1'b1);
      check("stream_busy", busy, 1'b1);
      check("stream_done_low", done, 1'b0);
      check("beat_log_regs", rlog, el);
      check("beat_phys_map", rphy, ep);
      if (rdy) beat++;
      @(negedge clk);
      cyc++;
    end
    cv = 0; flag = 0; rdy = 1;
    check("beat_cycles", cyc, exp_cycles);
    check("done_pulse", done, 1'b1);
    check("done_valid_low", rvalid, 1'b0);
    check("done_busy", busy, 1'b1);
    @(negedge clk);
    check("after_done_low", done, 1'b0);
    check("after_busy_low", busy, 1'b0);
  endtask

  initial begin
    // commit vectors, applied in order in IDLE; tags of invalid slots are don't-care
    vt[0] = '{4'b0001, pd(0, 0, 0, 5),    pp(0, 0, 0, 40),       4'b0001, pp(0, 0, 0, 5)};
    vt[1] = '{4'b1101, pd(7, 7, 7, 7),    pp(35, 34, 99, 33),    4'b1101, pp(7, 34, 0, 33)};
    vt[2] = '{4'b1111, pd(31, 0, 5, 7),   pp(62, 61, 60, 50),    4'b1111, pp(31, 0, 40, 35)};
    vt[3] = '{4'b1111, pd(4, 3, 4, 3),    pp(73, 72, 71, 70),    4'b1111, pp(4, 3, 71, 70)};
    vt[4] = '{4'b0000, pd(1, 2, 3, 4),    pp(9, 9, 9, 9),        4'b0000, pp(0, 0, 0, 0)};

    // reset state
    #3;
    check("reset_valid", rvalid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_phys_map", rphy, 28'd0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("post_reset_rel_valid", rel_v, 4'b0000);
    check("post_reset_busy", busy, 1'b0);

    // identity stream
    set_identity();
    do_recovery(0, 0, 8);

    // commit vectors
    for (int v = 0; v < 5; v++) begin
      logic [27:0] m;
      cv = vt[v].vld; cd = vt[v].dest; cp = vt[v].phy;
      #1;
      for (int k = 0; k < 4; k++) m[k*7 +: 7] = vt[v].exp_rv[k] ? 7'h7f : 7'h0;
      check($sformatf("vec%0d_rel_valid", v), rel_v, vt[v].exp_rv);
      check($sformatf("vec%0d_rel_tags", v), rel_p & m, vt[v].exp_rel & m);
      @(negedge clk);
    end
    cv = 0;
    exp_amt[5] = 60; exp_amt[7] = 50; exp_amt[0] = 61; exp_amt[31] = 62;
    exp_amt[3] = 72; exp_amt[4] = 73;
    do_recovery(0, 0, 8);

    // commit in the flag cycle, backpressure, ignored commits and flag mid-stream
    exp_amt[10] = 90;
    do_recovery(1, 1, 16);
    // second recovery confirms the table stayed frozen during the stream
    do_recovery(0, 0, 8);

    // asynchronous reset at beat 3
    @(negedge clk);
    flag = 1;
    @(negedge clk);
    flag = 0;
    repeat (3) @(negedge clk);
    check("pre_reset_beat3", rlog[4:0], 5'd12);
    #2 reset = 0;
    #1;
    check("async_reset_valid", rvalid, 1'b0);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", done, 1'b0);
    check("async_reset_phys_map", rphy, 28'd0);
    @(negedge clk);
    reset = 1;
    set_identity();
    do_recovery(0, 0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
